// File: rtl/am_ctrl_pkg.sv
// Shared types and constants for the AM modulator controller.
package am_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int LAT_DEF = 4;

  // Largest positive Q1.(dw-1) value; the modulation index never exceeds it.
  function automatic int idx_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

endpackage

// File: rtl/am_index_ramp.sv
// Modulation-index target/step store with a saturating step-toward-target ramp.
module am_index_ramp
  import am_ctrl_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 tick_i,
  input  logic                 jump_i,
  input  logic signed [DW-1:0] target_i,
  input  logic        [DW-2:0] step_i,
  output logic signed [DW-1:0] index_o,
  output logic                 ramping_o
);

  localparam logic signed [DW:0] IDX_MAX_W = (DW+1)'(idx_max(DW));

  logic signed [DW-1:0] tgt_q, tgt_d;
  logic        [DW-2:0] step_q, step_d;
  logic signed [DW-1:0] idx_q, idx_d;
  logic                 ramp_q, ramp_d;
  logic signed [DW:0]   tgt_w;

  // Negative targets become 0; the upper bound is the positive full scale.
  function automatic logic signed [DW:0] clamp_tgt(input logic signed [DW-1:0] t);
    logic signed [DW:0] w;
    w = {t[DW-1], t};
    if (w < 0) return '0;
    if (w > IDX_MAX_W) return IDX_MAX_W;
    return w;
  endfunction

  // One step toward the target in DW+1 bits, never passing it; step 0 jumps.
  function automatic logic signed [DW-1:0] step_toward(input logic signed [DW-1:0] cur,
                                                       input logic signed [DW-1:0] tgt,
                                                       input logic        [DW-2:0] stp);
    logic signed [DW:0] c;
    logic signed [DW:0] t;
    logic signed [DW:0] s;
    logic signed [DW:0] n;
    c = {cur[DW-1], cur};
    t = {tgt[DW-1], tgt};
    s = {2'b00, stp};
    if (stp == '0) begin
      n = t;
    end else if (c < t) begin
      n = c + s;
      if (n > t) n = t;
    end else if (c > t) begin
      n = c - s;
      if (n < t) n = t;
    end else begin
      n = t;
    end
    return n[DW-1:0];
  endfunction

  // Next target/step on load; index jumps when idle or steps on each running sample.
  always_comb begin
    tgt_w  = '0;
    tgt_d  = tgt_q;
    step_d = step_q;
    idx_d  = idx_q;
    if (load_i) begin
      tgt_w  = clamp_tgt(target_i);
      tgt_d  = tgt_w[DW-1:0];
      step_d = step_i;
    end
    if (jump_i) begin
      idx_d = tgt_d;
    end else if (tick_i) begin
      idx_d = step_toward(idx_q, tgt_q, step_q);
    end
    ramp_d = (idx_d != tgt_d);
  end

  // Ramp state registers; reset discards any pending ramp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q  <= '0;
      step_q <= '0;
      idx_q  <= '0;
      ramp_q <= 1'b0;
    end else begin
      tgt_q  <= tgt_d;
      step_q <= step_d;
      idx_q  <= idx_d;
      ramp_q <= ramp_d;
    end
  end

  assign index_o   = idx_q;
  assign ramping_o = ramp_q;

endmodule

// File: rtl/am_mod_ctrl.sv
// AM modulator sequencer: enable gating, pipeline-fill tracking and config handshake.
module am_mod_ctrl
  import am_ctrl_pkg::*;
#(
  parameter int DW  = 12,
  parameter int LAT = LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 smp_valid,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic signed [DW-1:0] cfg_shift,
  input  logic signed [DW-1:0] cfg_index,
  input  logic        [DW-2:0] cfg_step,
  output logic                 mod_en,
  output logic                 mod_clr,
  output logic signed [DW-1:0] mod_shift,
  output logic signed [DW-1:0] mod_index,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 ramping
);

  localparam int            CW    = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 clr_q, clr_d;
  logic                 ov_q, ov_d;
  logic signed [DW-1:0] shift_q, shift_d;
  logic signed [DW-1:0] pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 running;
  logic                 accept;

  assign running   = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign mod_en    = running && smp_valid;
  assign busy      = (state_q != ST_IDLE);
  assign cfg_ready = !ramping;
  assign accept    = cfg_valid && cfg_ready;
  assign mod_clr   = clr_q;
  assign out_valid = ov_q;
  assign mod_shift = shift_q;

  // Next state, saturating fill count, flush strobe and output-valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      ST_FILL, ST_RUN: begin
        if (mod_en && (cnt_q != LAT_C)) cnt_d = cnt_q + CW'(1);
        if (stop)                       state_d = ST_FLUSH;
        else if (cnt_d == LAT_C)        state_d = ST_RUN;
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    clr_d = (state_d == ST_FLUSH);
    ov_d  = mod_en && (cnt_q >= LAT_C - CW'(1));
  end

  // Shift is applied at once when not running, otherwise held until the next sample.
  always_comb begin
    shift_d    = shift_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (pend_vld_q && (!running || smp_valid)) begin
      shift_d    = pend_q;
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      if (running) begin
        pend_d     = cfg_shift;
        pend_vld_d = 1'b1;
      end else begin
        shift_d    = cfg_shift;
        pend_vld_d = 1'b0;
      end
    end
  end

  // Control and shift registers; mod_clr comes out of reset asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      clr_q      <= 1'b1;
      ov_q       <= 1'b0;
      shift_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_q      <= clr_d;
      ov_q       <= ov_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  am_index_ramp #(.DW(DW)) u_ramp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .tick_i    (mod_en),
    .jump_i    (!running),
    .target_i  (cfg_index),
    .step_i    (cfg_step),
    .index_o   (mod_index),
    .ramping_o (ramping)
  );

endmodule

// File: tb/tb_am_mod_ctrl.sv
// Scoreboard bench for am_mod_ctrl: stimulus queues expected observations, a negedge monitor checks them.
module tb_am_mod_ctrl;

  localparam int DW  = 12;
  localparam int LAT = 4;

  localparam int S_CLR   = 0;
  localparam int S_EN    = 1;
  localparam int S_BUSY  = 2;
  localparam int S_RAMP  = 3;
  localparam int S_RDY   = 4;
  localparam int S_SHIFT = 5;
  localparam int S_IDX   = 6;
  localparam int S_OV    = 7;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start, stop, smp_valid, cfg_valid;
  logic                 cfg_ready;
  logic signed [DW-1:0] cfg_shift, cfg_index;
  logic        [DW-2:0] cfg_step;
  logic                 mod_en, mod_clr, out_valid, busy, ramping;
  logic signed [DW-1:0] mod_shift, mod_index;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } chk_t;

  chk_t  exp_q[$];
  int    ov_q[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  chk_t  mc;
  int    mn;
  int    got;

  am_mod_ctrl #(.DW(DW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .smp_valid (smp_valid),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_shift (cfg_shift),
    .cfg_index (cfg_index),
    .cfg_step  (cfg_step),
    .mod_en    (mod_en),
    .mod_clr   (mod_clr),
    .mod_shift (mod_shift),
    .mod_index (mod_index),
    .out_valid (out_valid),
    .busy      (busy),
    .ramping   (ramping)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sig_val(input int s);
    case (s)
      S_CLR:   return int'(mod_clr);
      S_EN:    return int'(mod_en);
      S_BUSY:  return int'(busy);
      S_RAMP:  return int'(ramping);
      S_RDY:   return int'(cfg_ready);
      S_SHIFT: return int'($unsigned(mod_shift));
      S_IDX:   return int'($unsigned(mod_index));
      default: return int'(out_valid);
    endcase
  endfunction

  // Monitor: compare every observation due this cycle, and the out_valid stream.
  always @(negedge clk) begin
    mn = exp_q.size();
    for (int i = 0; i < mn; i++) begin
      mc = exp_q.pop_front();
      if (mc.cyc == cyc) begin
        got = sig_val(mc.sig);
        checks++;
        if (got != mc.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", mc.name, cyc, got, mc.val);
        end
      end else begin
        exp_q.push_back(mc);
      end
    end
    if (ov_q.size() > 0 && ov_q[0] == cyc) begin
      void'(ov_q.pop_front());
      checks++;
      if (!out_valid) begin
        errors++;
        $display("FAIL out_valid_missing cyc=%0d got=0 exp=1", cyc);
      end
    end else if (out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_unexpected cyc=%0d got=1 exp=0", cyc);
    end
  end

  task automatic expect_at(input int dc, input int s, input int v, input string nm);
    chk_t c;
    c.cyc  = cyc + dc;
    c.sig  = s;
    c.val  = v;
    c.name = nm;
    exp_q.push_back(c);
  endtask

  task automatic expect_ov();
    ov_q.push_back(cyc + 1);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    start     = 1'b0;
    stop      = 1'b0;
    smp_valid = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic cfg(input int sh, input int ix, input int st);
    cfg_valid = 1'b1;
    cfg_shift = DW'(sh);
    cfg_index = DW'(ix);
    cfg_step  = (DW-1)'(st);
  endtask

  // Wait two idle cycles, then present one sample in a third.
  task automatic sample3(input bit want_ov);
    nxt();
    nxt();
    nxt();
    smp_valid = 1'b1;
    expect_at(0, S_EN, 1, "fill_en");
    if (want_ov) expect_ov();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; smp_valid = 1'b0; cfg_valid = 1'b0;
    cfg_shift = '0; cfg_index = '0; cfg_step = '0;

    // Reset values while rst_n is held low.
    nxt();
    nxt();
    expect_at(0, S_CLR, 1, "rst_clr");
    expect_at(0, S_EN, 0, "rst_en");
    expect_at(0, S_BUSY, 0, "rst_busy");
    expect_at(0, S_RAMP, 0, "rst_ramping");
    expect_at(0, S_RDY, 1, "rst_ready");
    expect_at(0, S_SHIFT, 0, "rst_shift");
    expect_at(0, S_IDX, 0, "rst_index");
    nxt();
    rst_n = 1'b1;
    expect_at(0, S_CLR, 1, "rel_clr_hold");
    expect_at(1, S_CLR, 0, "rel_clr_drop");
    nxt();

    // IDLE config: immediate shift and index, one transfer per cycle, negative clamp.
    nxt();
    cfg(12'h123, 12'h400, 0);
    expect_at(0, S_RDY, 1, "idle_ready");
    expect_at(1, S_SHIFT, 12'h123, "idle_shift");
    expect_at(1, S_IDX, 12'h400, "idle_index_jump");
    expect_at(1, S_RAMP, 0, "idle_no_ramp");
    nxt();
    cfg(12'h055, -5, 0);
    expect_at(0, S_RDY, 1, "idle_ready_b2b");
    expect_at(1, S_IDX, 0, "idle_neg_clamp");
    expect_at(1, S_SHIFT, 12'h055, "idle_shift_b2b");
    nxt();
    smp_valid = 1'b1;
    expect_at(0, S_EN, 0, "idle_en_gated");

    // Fill: sample every third cycle, out_valid after the 4th enable.
    nxt();
    start = 1'b1;
    expect_at(1, S_BUSY, 1, "start_busy");
    for (int k = 0; k < 6; k++) sample3(k >= LAT - 1);
    nxt();
    expect_at(0, S_EN, 0, "run_no_smp_en");

    // Ramp in RUN: 0 -> 0x100 in 0x40 steps; shift waits for the first sample.
    nxt();
    cfg(12'h200, 12'h100, 12'h040);
    expect_at(0, S_RDY, 1, "ramp_ready_pre");
    expect_at(1, S_RAMP, 1, "ramp_flag");
    expect_at(1, S_RDY, 0, "ramp_ready_low");
    expect_at(1, S_IDX, 0, "ramp_idx_hold");
    expect_at(1, S_SHIFT, 12'h055, "shift_deferred");
    nxt();
    cfg(12'h111, 12'h333, 0);
    for (int i = 1; i <= 4; i++) begin
      nxt();
      nxt();
      smp_valid = 1'b1;
      expect_ov();
      expect_at(1, S_IDX, 12'h040 * i, "ramp_step");
      if (i == 1) expect_at(1, S_SHIFT, 12'h200, "shift_on_sample");
      expect_at(1, S_RDY, (i == 4) ? 1 : 0, "ramp_ready");
    end
    nxt();
    expect_at(0, S_RAMP, 0, "ramp_done");

    // Jump to 0x400, then target 0x7FF with step 0x500 must stop at 0x7FF.
    nxt();
    cfg(12'h200, 12'h400, 0);
    expect_at(1, S_RAMP, 1, "jump_pending");
    nxt();
    smp_valid = 1'b1;
    expect_ov();
    expect_at(1, S_IDX, 12'h400, "run_jump");
    expect_at(1, S_RAMP, 0, "run_jump_done");
    nxt();
    cfg(12'h200, 12'h7FF, 12'h500);
    expect_at(1, S_RDY, 0, "ovs_ready_low");
    nxt();
    smp_valid = 1'b1;
    expect_ov();
    expect_at(1, S_IDX, 12'h7FF, "no_overshoot");
    expect_at(1, S_RDY, 1, "ovs_ready_high");

    // Negative target with step 0 in RUN clamps to 0.
    nxt();
    cfg(12'h200, -5, 0);
    nxt();
    smp_valid = 1'b1;
    expect_ov();
    expect_at(1, S_IDX, 0, "run_neg_clamp");

    // start+stop in RUN: one-cycle flush with enable gated, then IDLE.
    nxt();
    start = 1'b1;
    stop  = 1'b1;
    expect_at(1, S_CLR, 1, "flush_clr");
    nxt();
    smp_valid = 1'b1;
    expect_at(0, S_EN, 0, "flush_en");
    expect_at(0, S_BUSY, 1, "flush_busy");
    nxt();
    expect_at(0, S_CLR, 0, "idle_clr");
    expect_at(0, S_BUSY, 0, "idle_after_flush");
    start = 1'b1;
    stop  = 1'b1;
    expect_at(1, S_BUSY, 0, "idle_start_stop_ignored");
    nxt();

    // Restart needs four fresh enables.
    nxt();
    start = 1'b1;
    for (int k = 0; k < 5; k++) sample3(k >= LAT - 1);

    // Async reset in the middle of a ramp.
    nxt();
    cfg(12'h200, 12'h600, 12'h010);
    nxt();
    smp_valid = 1'b1;
    expect_ov();
    expect_at(1, S_IDX, 12'h010, "pre_rst_step");
    expect_at(1, S_RAMP, 1, "pre_rst_ramp");
    nxt();
    nxt();
    rst_n = 1'b0;
    expect_at(0, S_IDX, 0, "arst_index");
    expect_at(0, S_RAMP, 0, "arst_ramping");
    expect_at(0, S_BUSY, 0, "arst_busy");
    expect_at(0, S_CLR, 1, "arst_clr");
    expect_at(0, S_SHIFT, 0, "arst_shift");
    nxt();
    rst_n = 1'b1;
    nxt();
    nxt();
    smp_valid = 1'b1;
    expect_at(0, S_IDX, 0, "post_rst_index");
    expect_at(0, S_BUSY, 0, "post_rst_idle");
    expect_at(0, S_RDY, 1, "post_rst_ready");
    expect_at(0, S_EN, 0, "post_rst_en");

    nxt();
    nxt();
    nxt();
    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s cyc=%0d got=unchecked exp=checked", exp_q[i].name, exp_q[i].cyc);
    end
    foreach (ov_q[i]) begin
      checks++;
      errors++;
      $display("FAIL out_valid_pending cyc=%0d got=unchecked exp=checked", ov_q[i]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
